product_to_bcd: RTL and testbench

PRODUCT_TO_BCD -- requirements
Module: product_to_bcd

---
 rtl/product_to_bcd_if.sv | 22 ++
 rtl/product_to_bcd.sv | 96 +++++++++
 tb/tb_product_to_bcd.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/product_to_bcd_if.sv
// Request/result bundle between a digit multiplier and the binary-to-BCD converter.
// master drives the request, slave (the converter) returns status and digits.
interface product_to_bcd_if;
  logic       start;
  logic [7:0] prod;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       over_range;

  modport master (
    output start, prod,
    input  busy, done, hundreds, tens, ones, over_range
  );

  modport slave (
    input  start, prod,
    output busy, done, hundreds, tens, ones, over_range
  );
endinterface

// File: rtl/product_to_bcd.sv
// Sequential double-dabble converter: 8-bit product to three BCD digits in a fixed
// eight SHIFT cycles, with a one-cycle done pulse and back-to-back restart from DONE.
module product_to_bcd (
  input  logic              clk,
  input  logic              reset,
  product_to_bcd_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [7:0]  shift_q;
  logic [11:0] acc_q;
  logic [2:0]  cnt_q;
  logic        over_pend_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  hundreds_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;
  logic        over_q;

  logic [11:0] acc_adj;
  logic [19:0] shifted;

  // One double-dabble step: per-nibble add-3 correction, then a joint left shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 3; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {acc_adj, shift_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= 8'd0;
      acc_q       <= 12'd0;
      cnt_q       <= 3'd0;
      over_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hundreds_q  <= 4'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      over_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            shift_q     <= bus.prod;
            acc_q       <= 12'd0;
            cnt_q       <= 3'd0;
            over_pend_q <= (bus.prod > 8'd81);
            state_q     <= StShift;
            busy_q      <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StShift: begin
          // start and prod are deliberately ignored here.
          {acc_q, shift_q} <= shifted;
          cnt_q            <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            hundreds_q <= shifted[19:16];
            tens_q     <= shifted[15:12];
            ones_q     <= shifted[11:8];
            over_q     <= over_pend_q;
            state_q    <= StDone;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hundreds   = hundreds_q;
  assign bus.tens       = tens_q;
  assign bus.ones       = ones_q;
  assign bus.over_range = over_q;

endmodule

// File: tb/tb_product_to_bcd.sv
// Directed bench for product_to_bcd: fixed vectors with hand-computed digits,
// abort/restart scenarios and the full 0-9 x 0-9 product sweep.
module tb_product_to_bcd;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;
  logic [3:0] prev_h, prev_t, prev_o;
  logic       prev_ov;

  product_to_bcd_if bus ();

  product_to_bcd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drives a one-cycle request now (accepted at the next edge) and checks timing and result.
  task automatic convert(input logic [7:0] p, input logic [3:0] eh, input logic [3:0] et,
                         input logic [3:0] eo, input logic eov);
    int n;
    int busy_cnt;
    bus.start = 1'b1;
    bus.prod  = p;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.prod  = ~p;
    n        = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (n == 4) begin
        check($sformatf("hold_h p=%0d", p), bus.hundreds, prev_h);
        check($sformatf("hold_t p=%0d", p), bus.tens, prev_t);
        check($sformatf("hold_o p=%0d", p), bus.ones, prev_o);
        check($sformatf("hold_ov p=%0d", p), bus.over_range, prev_ov);
      end
    end
    last_done_cyc = cyc;
    check($sformatf("latency p=%0d", p), n, 8);
    check($sformatf("busy_cycles p=%0d", p), busy_cnt, 8);
    check($sformatf("busy_at_done p=%0d", p), bus.busy, 0);
    check($sformatf("hundreds p=%0d", p), bus.hundreds, eh);
    check($sformatf("tens p=%0d", p), bus.tens, et);
    check($sformatf("ones p=%0d", p), bus.ones, eo);
    check($sformatf("over p=%0d", p), bus.over_range, eov);
    prev_h  = eh;
    prev_t  = et;
    prev_o  = eo;
    prev_ov = eov;
  endtask

  initial begin
    int n_done;
    int first_done;
    int d0;
    logic [3:0] gh, gt, go;
    logic [7:0] pr;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.prod  = 8'd0;
    prev_h = 0; prev_t = 0; prev_o = 0; prev_ov = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_digits", {bus.hundreds, bus.tens, bus.ones}, 12'h000);
    check("rst_over", bus.over_range, 0);
    @(negedge clk);
    reset = 1'b0;

    @(negedge clk); convert(8'd81, 4'd0, 4'd8, 4'd1, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 0);
    @(negedge clk); convert(8'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    @(negedge clk); convert(8'd255, 4'd2, 4'd5, 4'd5, 1'b1);
    @(negedge clk); convert(8'd82, 4'd0, 4'd8, 4'd2, 1'b1);
    @(negedge clk); convert(8'd100, 4'd1, 4'd0, 4'd0, 1'b1);
    @(negedge clk); convert(8'd199, 4'd1, 4'd9, 4'd9, 1'b1);

    // Second start during SHIFT is dropped; prod wiggles mid-conversion.
    @(negedge clk);
    bus.start = 1'b1; bus.prod = 8'd45;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.prod = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.prod = 8'd72;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.prod = 8'd200;
    n_done = 0; first_done = 0; gh = 0; gt = 0; go = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin
          first_done = i; gh = bus.hundreds; gt = bus.tens; go = bus.ones;
        end
      end
    end
    check("ignore_start_pulses", n_done, 1);
    check("ignore_start_latency", first_done, 5);
    check("ignore_start_digits", {gh, gt, go}, 12'h045);
    prev_h = 0; prev_t = 4; prev_o = 5; prev_ov = 0;

    // Reset in the 5th SHIFT cycle abandons the conversion.
    @(negedge clk);
    bus.start = 1'b1; bus.prod = 8'd63;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_digits", {bus.hundreds, bus.tens, bus.ones}, 12'h000);
    check("abort_over", bus.over_range, 0);
    n_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);
    prev_h = 0; prev_t = 0; prev_o = 0; prev_ov = 0;

    // Start in the very first cycle after reset release.
    @(negedge clk);
    reset = 1'b0;
    convert(8'd7, 4'd0, 4'd0, 4'd7, 1'b0);

    // Back-to-back: new request held during the done cycle.
    @(negedge clk); convert(8'd9, 4'd0, 4'd0, 4'd9, 1'b0);
    d0 = last_done_cyc;
    convert(8'd18, 4'd0, 4'd1, 4'd8, 1'b0);
    check("b2b_spacing", last_done_cyc - d0, 9);

    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        pr = 8'(a * b);
        @(negedge clk);
        convert(pr, 4'(pr / 100), 4'((pr / 10) % 10), 4'(pr % 10), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
